// File: rtl/mlx90640_pkg.sv
// Shared MLX90640 definitions.
//   MLX_WORDS    : words per full scan (768 pixels + 64 auxiliary words)
//   scan_state_t : subpage scan controller states
package mlx90640_pkg;

    localparam int MLX_WORDS = 32*24 + 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mlx90640_subpage_scan.sv
// Subpage scan controller. Walks every address of the raw sensor RAM and the
// subpage mask ROM pair in lockstep. It copies a raw word into the frame
// buffer only where the mask of the captured subpage is set.
//   clk, rst        : clock, synchronous active-high reset
//   start, subpage  : scan request; subpage latched when start is accepted
//   rom_addr        : address to the mask ROMs (sync, 1-cycle latency)
//   rom_data_pg0/1  : mask bits for subpage 0 / subpage 1
//   raw_addr        : address to raw RAM (mirrors rom_addr)
//   raw_data        : raw word (sync, 1-cycle latency)
//   fb_we/addr/data : frame-buffer write port
//   busy, done      : scan in progress / one-cycle end-of-scan pulse
//   update_count    : frame-buffer writes in the current or last scan
module mlx90640_subpage_scan
    import mlx90640_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = MLX_WORDS,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             subpage,
    output logic [ADDRW-1:0] rom_addr,
    input  logic             rom_data_pg0,
    input  logic             rom_data_pg1,
    output logic [ADDRW-1:0] raw_addr,
    input  logic [WIDTH-1:0] raw_data,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [WIDTH-1:0] fb_data,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  update_count
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH-1);
    localparam logic [CNTW-1:0]  CNT_MAX   = CNTW'(DEPTH);

    scan_state_t      state, nstate;
    logic [ADDRW-1:0] addr_d;
    logic             valid_d;
    logic             sp_q;
    logic             sel;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && start;
    assign last   = (rom_addr == LAST_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = SCAN;
            SCAN:    if (last)  nstate = FLUSH;
            FLUSH:   nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN, FLUSH: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    // Address walk plus a one-stage tag pipeline that lines the presented
    // address up with the sync memories' output data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr     <= '0;
            addr_d       <= '0;
            valid_d      <= 1'b0;
            sp_q         <= 1'b0;
            update_count <= '0;
        end else begin
            // Every SCAN cycle presents one address, including the held last one.
            valid_d <= (state == SCAN);
            addr_d  <= rom_addr;

            if (accept) begin
                sp_q     <= subpage;
                rom_addr <= '0;
            end else if (state == SCAN && !last) begin
                rom_addr <= rom_addr + 1'b1;
            end

            if (accept)
                update_count <= '0;
            else if (fb_we && update_count != CNT_MAX)
                update_count <= update_count + 1'b1;
        end
    end

    assign raw_addr = rom_addr;
    assign sel      = sp_q ? rom_data_pg1 : rom_data_pg0;
    assign fb_we    = valid_d & sel;
    assign fb_addr  = addr_d;
    assign fb_data  = raw_data;

endmodule

// File: tb/tb_mlx90640_subpage_scan.sv
// Randomized self-checking bench for mlx90640_subpage_scan. A reference
// model predicts the ordered list of frame-buffer writes and the cycle of
// each write. The bench builds this list from the mask rule and the scan
// timing, then checks every write against it.
module tb_mlx90640_subpage_scan;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 832;
    localparam int ADDRW    = $clog2(DEPTH);
    localparam int CNTW     = $clog2(DEPTH+1);
    localparam int SCAN_LAT = DEPTH + 2;   // accept -> done
    localparam int SCAN_PER = DEPTH + 3;   // accept -> next accept with start held

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             subpage = 1'b0;
    logic [ADDRW-1:0] rom_addr, raw_addr, fb_addr;
    logic             rom_pg0, rom_pg1;
    logic [WIDTH-1:0] raw_data, fb_data;
    logic             fb_we, busy, done;
    logic [CNTW-1:0]  update_count;

    always #5 clk = ~clk;

    mlx90640_subpage_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .subpage      (subpage),
        .rom_addr     (rom_addr),
        .rom_data_pg0 (rom_pg0),
        .rom_data_pg1 (rom_pg1),
        .raw_addr     (raw_addr),
        .raw_data     (raw_data),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .busy         (busy),
        .done         (done),
        .update_count (update_count)
    );

    // Sync ROM pair and raw RAM models, 1-cycle latency.
    always @(posedge clk) begin
        rom_pg0  <= rom_addr[0] ^ rom_addr[5];
        raw_data <= WIDTH'(raw_addr) + 16'h1000;
    end
    assign rom_pg1 = ~rom_pg0;

    typedef struct { int a; int c; } wr_t;
    wr_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit cov [DEPTH];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit mask(input int a, input bit sp);
        bit m;
        m = a[0] ^ a[5];
        return sp ? ~m : m;
    endfunction

    // Queue the expected writes of one scan accepted in cycle acc.
    function automatic int add_scan(input bit sp, input int acc);
        int n = 0;
        for (int k = 0; k < DEPTH; k++)
            if (mask(k, sp)) begin
                exp_q.push_back('{k, acc + k + 2});
                n++;
            end
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && fb_we) begin
            if (exp_q.size() == 0) begin
                chk("wr_extra", longint'(fb_addr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", fb_addr, e.a);
                chk("wr_data", fb_data, (e.a + 'h1000) & 'hffff);
                chk("wr_cyc", cyc, e.c);
                cov[fb_addr] = 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input int exp_cnt,
                             input bit noisy, input bit hold);
        bit seen = 0;
        int n = 0;
        while (!seen && n < 2*DEPTH) begin
            tick;
            n++;
            if (done) begin
                seen = 1;
                chk({tag, "_lat"}, cyc, exp_cyc);
                chk({tag, "_busy"}, busy, 0);
                chk({tag, "_cnt"}, update_count, exp_cnt);
                if (!hold) start = 1'b0;
            end else if (noisy) begin
                start   = 1'($urandom_range(0, 1));
                subpage = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    // One scan from IDLE; returns the predicted write count.
    task automatic run_scan(input bit sp, input bit noisy, input string tag, output int n);
        int acc, d0;
        start   = 1'b1;
        subpage = sp;
        acc     = cyc;
        n       = add_scan(sp, acc);
        d0      = done_cnt;
        tick;
        chk({tag, "_busy1"}, busy, 1);
        start = 1'b0;
        wait_done(tag, acc + SCAN_LAT, n, noisy, 0);
        repeat (3) tick;
        chk({tag, "_qleft"}, exp_q.size(), 0);
        chk({tag, "_ndone"}, done_cnt - d0, 1);
        chk({tag, "_hold"}, update_count, n);
    endtask

    initial begin
        int n, acc, d0, miss;
        bit sp, found;

        #(10*200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, acc, d0, miss;
        bit sp, found;

        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_cnt", update_count, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b0;
        tick;

        // Both subpages, clean; their write sets must tile the whole array.
        run_scan(1'b0, 1'b0, "sp0", n);
        chk("sp0_n416", n, 416);
        run_scan(1'b1, 1'b0, "sp1", n);
        chk("sp1_n416", n, 416);
        miss = 0;
        for (int a = 0; a < DEPTH; a++) if (!cov[a]) miss++;
        chk("cov_union", miss, 0);

        // start/subpage noise during the scan is ignored.
        run_scan(1'($urandom_range(0, 1)), 1'b1, "noisy", n);

        // Abort at rom_addr 300.
        start   = 1'b1;
        subpage = 1'($urandom_range(0, 1));
        acc     = cyc;
        n       = add_scan(subpage, acc);
        tick;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < DEPTH && !found; i++) begin
            if (rom_addr == 300) found = 1;
            else tick;
        end
        chk("abort_reach300", found, 1);
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        tick;
        rst = 1'b0;
        chk("abort_we", fb_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", update_count, 0);
        chk("abort_done", done, 0);
        repeat (DEPTH + 10) tick;
        chk("abort_nodone", done_cnt - d0, 0);

        run_scan(1'($urandom_range(0, 1)), 1'b0, "post_rst", n);

        // Reset wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        tick;
        chk("rst_prio_busy2", busy, 0);

        // start held for three back-to-back scans.
        sp      = 1'($urandom_range(0, 1));
        start   = 1'b1;
        subpage = sp;
        acc     = cyc;
        d0      = done_cnt;
        for (int i = 0; i < 3; i++) n = add_scan(sp, acc + i*SCAN_PER);
        for (int i = 0; i < 3; i++)
            wait_done($sformatf("b2b%0d", i), acc + i*SCAN_PER + SCAN_LAT, n, 1'b0, i < 2);
        repeat (3) tick;
        chk("b2b_qleft", exp_q.size(), 0);
        chk("b2b_ndone", done_cnt - d0, 3);
        chk("b2b_idle", busy, 0);

        // A few random scans with random idle gaps.
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 5)) tick;
            run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", i), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mlx90640_subpage_scan.md
MLX90640_SUBPAGE_SCAN -- requirements
Module: mlx90640_subpage_scan

Interface
REQ-001 Parameter WIDTH, default 16: raw pixel word width.
REQ-002 Parameter DEPTH, default 32*24+64 (832): words per scan, 768 pixels plus 64 auxiliary words.
REQ-003 Localparam ADDRW = $clog2(DEPTH); CNTW = $clog2(DEPTH+1).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one scan; sampled only in IDLE.
REQ-007 subpage  input  1  subpage just captured by the sensor; latched on an accepted start.
REQ-008 rom_addr  output  ADDRW  address to the subpage mask ROM pair.
REQ-009 rom_data_pg0  input  1  subpage-0 mask bit; sync ROM, valid 1 cycle after rom_addr.
REQ-010 rom_data_pg1  input  1  subpage-1 mask bit; same timing.
REQ-011 raw_addr  output  ADDRW  address to raw sensor RAM; always equals rom_addr.
REQ-012 raw_data  input  WIDTH  raw word; valid 1 cycle after raw_addr.
REQ-013 fb_we  output  1  frame-buffer write strobe.
REQ-014 fb_addr  output  ADDRW  frame-buffer write address.
REQ-015 fb_data  output  WIDTH  frame-buffer write data.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  single-cycle pulse at end of scan.
REQ-018 update_count  output  CNTW  number of fb writes in the current or last scan.

Function
REQ-019 FSM states: IDLE, SCAN, FLUSH, DONE.
REQ-020 IDLE: start=1 latches subpage into sp_q, clears update_count, sets rom_addr=0, goes to SCAN. start=0 stays in IDLE.
REQ-021 SCAN: rom_addr increments by 1 per cycle. In the cycle rom_addr=DEPTH-1 it holds and the FSM moves to FLUSH. No wrap-around.
REQ-022 FLUSH: one cycle, so the last address's data is consumed. Then DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-024 Pipeline: a 1-cycle delayed copy addr_d and valid_d track each presented address. The mask bit is sel = sp_q ? rom_data_pg1 : rom_data_pg0.
REQ-025 fb_we = valid_d & sel; fb_addr = addr_d; fb_data = raw_data. All are combinational from the registered pipeline and memory outputs, so each address is written in the cycle after it was presented.
REQ-026 Latency: the write for address k occurs k+2 cycles after the start-accept cycle. Total start-accept to done pulse is DEPTH+2 cycles.
REQ-027 update_count increments on every fb_we cycle, saturates at DEPTH, and holds its value after done until the next accepted start.
REQ-028 start while busy (SCAN/FLUSH/DONE) is ignored. Changes to subpage mid-scan are ignored (sp_q is used).
REQ-029 start asserted in the DONE cycle is ignored. start held high continuously gives back-to-back scans with one IDLE cycle between them.
REQ-030 Both mask bits may be 1 for one address: only the sp_q-selected bit matters. Both 0: no write.

Reset
REQ-031 On rst: state=IDLE, rom_addr=0, addr_d=0, valid_d=0, sp_q=0, update_count=0, busy=0, done=0, fb_we=0.
REQ-032 rst mid-scan aborts immediately: no fb_we in the cycle after rst, and no done pulse for the aborted scan.
REQ-033 rst takes priority over start in the same cycle.

Structure
REQ-034 State enum (IDLE/SCAN/FLUSH/DONE) and the default DEPTH constant (MLX_WORDS=832) shall live in the shared mlx90640 package.
REQ-035 No sub-module is required. The top-level integration instantiates mlx90640_subpage_scan next to mlx90640_subpages_rom_sync and the raw RAM.

Verification
REQ-036 Bench models ROMs with pg0 = addr[0]^addr[5] and pg1 = its inverse, and raw RAM with data = addr+16'h1000, both with 1-cycle latency. It checks every fb write address/data against this model.
REQ-037 subpage=0, pulse start -> 416 writes, each fb_data=fb_addr+16'h1000, first write addr 1; done exactly 834 cycles after start accept; update_count=416.
REQ-038 subpage=1 -> 416 writes at the complementary addresses, first write addr 0, last write addr 831; union with the REQ-037 set covers 0..831.
REQ-039 Toggle subpage and pulse start repeatedly during a scan -> write set identical to REQ-037; exactly one done pulse.
REQ-040 Assert rst at rom_addr=300 -> fb_we=0 from the next cycle, no done pulse, busy=0, update_count=0. A following start gives a full correct scan.
REQ-041 Hold start high for 3 scans -> three done pulses spaced DEPTH+3 cycles apart; update_count=416 after each.
